// File: rtl/lasd_loader_pkg.sv
// Shared constants and state encodings for the UART instruction loader.
// The CSUM state only exists when LOADER_CHECKSUM_EN is defined.
package lasd_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } load_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop input synchronizer, mid-bit sampling,
// one-cycle valid pulse on a good stop bit, one-cycle ferr pulse on a bad one.
module uart_rx_byte
    import lasd_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iRXD,
    output logic [7:0] oDATA,
    output logic       oVALID,
    output logic       oFERR
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rxd_meta_q;
    logic             rxd_sync_q;
    logic             rxd_prev_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             valid_q;
    logic             ferr_q;

    // Line synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= iRXD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // Bit engine: start re-check at half a bit, then one sample per bit period.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (rxd_prev_q && !rxd_sync_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        bit_q   <= 3'd0;
                        state_q <= rxd_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rxd_sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        valid_q <= rxd_sync_q;
                        ferr_q  <= !rxd_sync_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign oDATA  = shift_q;
    assign oVALID = valid_q;
    assign oFERR  = ferr_q;

endmodule

// File: rtl/uart_inst_loader.sv
// Loads A5 / N / N x 4 big-endian bytes from UART into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR-of-data checksum byte.
module uart_inst_loader
    import lasd_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 8
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iRXD,
    output logic              oWE,
    output logic [ADDR_W-1:0] oADDR,
    output logic [31:0]       oDATA,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oERR
);

    logic [7:0]        rx_data_s;
    logic              rx_valid_s;
    logic              rx_ferr_s;

    load_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [8:0]        words_q;
    logic [1:0]        byte_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .iRXD  (iRXD),
        .oDATA (rx_data_s),
        .oVALID(rx_valid_s),
        .oFERR (rx_ferr_s)
    );

    // Frame FSM; the write address advances the cycle after every strobe.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= 32'd0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            words_q <= 9'd0;
            byte_q  <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (rx_valid_s && (rx_data_s == SYNC_BYTE)) begin
                        state_q <= COUNT;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        addr_q  <= '0;
                        byte_q  <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q  <= 8'd0;
`endif
                    end
                end
                COUNT: begin
                    if (rx_ferr_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (rx_valid_s) begin
                        words_q <= (rx_data_s == 8'd0) ? 9'd256 : {1'b0, rx_data_s};
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (rx_ferr_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (rx_valid_s) begin
                        data_q <= {data_q[23:0], rx_data_s};
                        byte_q <= byte_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_data_s;
`endif
                        if (byte_q == 2'd3) begin
                            we_q    <= 1'b1;
                            words_q <= words_q - 9'd1;
                            if (words_q == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q <= CSUM;
`else
                                state_q <= DONE;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (rx_ferr_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (rx_valid_s) begin
                        if (rx_data_s == csum_q) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oWE   = we_q;
    assign oADDR = addr_q;
    assign oDATA = data_q;
    assign oBUSY = busy_q;
    assign oDONE = done_q;
    assign oERR  = err_q;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Directed bench for uart_inst_loader; serial frames are bit-banged on iRXD
// and every write strobe is captured by a monitor for later comparison.
module tb_uart_inst_loader;

    localparam int CPB = 4;
    localparam int AW  = 8;

    logic          iCLK   = 1'b0;
    logic          iRST_N = 1'b1;
    logic          iRXD   = 1'b1;
    logic          oWE;
    logic [AW-1:0] oADDR;
    logic [31:0]   oDATA;
    logic          oBUSY;
    logic          oDONE;
    logic          oERR;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] we_addr_q[$];
    logic [31:0]   we_data_q[$];

    uart_inst_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .iRXD  (iRXD),
        .oWE   (oWE),
        .oADDR (oADDR),
        .oDATA (oDATA),
        .oBUSY (oBUSY),
        .oDONE (oDONE),
        .oERR  (oERR)
    );

    always #5 iCLK = ~iCLK;

    // Write-strobe monitor, sampled on the inactive edge.
    always @(negedge iCLK) begin
        if (oWE === 1'b1) begin
            we_addr_q.push_back(oADDR);
            we_data_q.push_back(oDATA);
        end
    end

    task automatic clear_log();
        we_addr_q.delete();
        we_data_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge iCLK);
        iRXD = 1'b0;
        repeat (CPB) @(negedge iCLK);
        for (int i = 0; i < 8; i++) begin
            iRXD = b[i];
            repeat (CPB) @(negedge iCLK);
        end
        iRXD = stop_bit;
        repeat (CPB) @(negedge iCLK);
        iRXD = 1'b1;
        repeat (CPB) @(negedge iCLK);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic settle();
        repeat (2 * CPB) @(negedge iCLK);
    endtask

    task automatic test_reset();
        #1 iRST_N = 1'b0;
        repeat (3) @(negedge iCLK);
        checks++; if (oWE !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", oWE); end
        checks++; if (oADDR !== 8'd0) begin failures++; $display("FAIL reset_addr: got %h want 00", oADDR); end
        checks++; if (oDATA !== 32'd0) begin failures++; $display("FAIL reset_data: got %h want 0", oDATA); end
        checks++; if ({oBUSY, oDONE, oERR} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {oBUSY, oDONE, oERR}); end
        iRST_N = 1'b1;
        repeat (3) @(negedge iCLK);
    endtask

    task automatic test_single_word();
        clear_log();
        send_ok(8'hA5);
        checks++; if (oBUSY !== 1'b1) begin failures++; $display("FAIL single_busy_after_sync: got %b want 1", oBUSY); end
        send_ok(8'h01);
        send_ok(8'h20);
        send_ok(8'h08);
        send_ok(8'h00);
        send_ok(8'h05);
        send_ok(8'h2D);
        settle();
        checks++; if (we_addr_q.size() !== 1) begin failures++; $display("FAIL single_we_count: got %0d want 1", we_addr_q.size()); end
        if (we_addr_q.size() >= 1) begin
            checks++; if (we_addr_q[0] !== 8'd0) begin failures++; $display("FAIL single_addr: got %h want 00", we_addr_q[0]); end
            checks++; if (we_data_q[0] !== 32'h20080005) begin failures++; $display("FAIL single_data: got %h want 20080005", we_data_q[0]); end
        end
        checks++; if ({oBUSY, oDONE, oERR} !== 3'b010) begin failures++; $display("FAIL single_flags busy/done/err: got %b want 010", {oBUSY, oDONE, oERR}); end
    endtask

    task automatic test_resync_ignore();
        clear_log();
        send_ok(8'h3C);
        send_ok(8'h11);
        checks++; if (oBUSY !== 1'b0) begin failures++; $display("FAIL resync_idle_busy: got %b want 0", oBUSY); end
        send_ok(8'hA5);
        send_ok(8'h02);
        for (int i = 0; i < 8; i++) begin
            send_ok(8'(i));
        end
        send_ok(8'h00);
        settle();
        checks++; if (we_addr_q.size() !== 2) begin failures++; $display("FAIL resync_we_count: got %0d want 2", we_addr_q.size()); end
        if (we_addr_q.size() >= 2) begin
            checks++; if ({we_addr_q[0], we_addr_q[1]} !== 16'h0001) begin failures++; $display("FAIL resync_addrs: got %h %h want 00 01", we_addr_q[0], we_addr_q[1]); end
            checks++; if (we_data_q[0] !== 32'h00010203) begin failures++; $display("FAIL resync_data0: got %h want 00010203", we_data_q[0]); end
            checks++; if (we_data_q[1] !== 32'h04050607) begin failures++; $display("FAIL resync_data1: got %h want 04050607", we_data_q[1]); end
        end
        checks++; if (oADDR !== 8'd2) begin failures++; $display("FAIL resync_final_addr: got %h want 02", oADDR); end
        checks++; if ({oBUSY, oDONE, oERR} !== 3'b010) begin failures++; $display("FAIL resync_flags: got %b want 010", {oBUSY, oDONE, oERR}); end
    endtask

    task automatic test_checksum();
        clear_log();
        send_ok(8'hA5);
        send_ok(8'h01);
        send_ok(8'h20);
        send_ok(8'h08);
        send_ok(8'h00);
        send_ok(8'h05);
        send_ok(8'h2C);
        settle();
        checks++; if (we_addr_q.size() !== 1) begin failures++; $display("FAIL csum_we_count: got %0d want 1", we_addr_q.size()); end
`ifdef LOADER_CHECKSUM_EN
        checks++; if ({oBUSY, oDONE, oERR} !== 3'b001) begin failures++; $display("FAIL csum_bad_flags: got %b want 001", {oBUSY, oDONE, oERR}); end
`else
        checks++; if ({oBUSY, oDONE, oERR} !== 3'b010) begin failures++; $display("FAIL csum_nocheck_flags: got %b want 010", {oBUSY, oDONE, oERR}); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0]  k8;
        logic [7:0]  xr;
        logic [31:0] w;
        int          bad;
        clear_log();
        xr  = 8'd0;
        bad = 0;
        send_ok(8'hA5);
        send_ok(8'h00);
        for (int k = 0; k < 256; k++) begin
            k8 = 8'(k);
            w  = {k8, 8'hA5, ~k8, k8 ^ 8'h3C};
            for (int j = 3; j >= 0; j--) begin
                send_ok(w[j*8 +: 8]);
                xr = xr ^ w[j*8 +: 8];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_ok(xr);
`endif
        settle();
        checks++; if (we_addr_q.size() !== 256) begin failures++; $display("FAIL full_we_count: got %0d want 256", we_addr_q.size()); end
        for (int k = 0; k < we_addr_q.size() && k < 256; k++) begin
            k8 = 8'(k);
            w  = {k8, 8'hA5, ~k8, k8 ^ 8'h3C};
            if (bad == 0 && (we_addr_q[k] !== k8 || we_data_q[k] !== w)) begin
                bad = k + 1;
                $display("word %0d: got addr %h data %h want addr %h data %h", k, we_addr_q[k], we_data_q[k], k8, w);
            end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL full_sequence: first bad word index %0d want none", bad - 1); end
        checks++; if (oADDR !== 8'd0) begin failures++; $display("FAIL full_addr_wrap: got %h want 00", oADDR); end
        checks++; if ({oBUSY, oDONE, oERR} !== 3'b010) begin failures++; $display("FAIL full_flags: got %b want 010", {oBUSY, oDONE, oERR}); end
    endtask

    task automatic test_framing_error();
        clear_log();
        send_ok(8'hA5);
        send_ok(8'h01);
        send_byte(8'h12, 1'b0);
        checks++; if ({oBUSY, oDONE, oERR} !== 3'b001) begin failures++; $display("FAIL ferr_flags: got %b want 001", {oBUSY, oDONE, oERR}); end
        send_ok(8'h34);
        send_ok(8'h56);
        send_ok(8'h78);
        settle();
        checks++; if (we_addr_q.size() !== 0) begin failures++; $display("FAIL ferr_we_count: got %0d want 0", we_addr_q.size()); end
        checks++; if (oERR !== 1'b1) begin failures++; $display("FAIL ferr_sticky: got %b want 1", oERR); end
    endtask

    task automatic test_reset_midframe();
        clear_log();
        send_ok(8'hA5);
        send_ok(8'h01);
        send_ok(8'h11);
        send_ok(8'h22);
        checks++; if (oBUSY !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b want 1", oBUSY); end
        iRST_N = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        send_ok(8'h33);
        send_ok(8'h44);
`ifdef LOADER_CHECKSUM_EN
        send_ok(8'h44);
`endif
        settle();
        checks++; if (we_addr_q.size() !== 0) begin failures++; $display("FAIL midrst_we_count: got %0d want 0", we_addr_q.size()); end
        checks++; if ({oADDR, oDATA} !== 40'd0) begin failures++; $display("FAIL midrst_addr_data: got %h %h want 00 00000000", oADDR, oDATA); end
        checks++; if ({oWE, oBUSY, oDONE, oERR} !== 4'b0000) begin failures++; $display("FAIL midrst_flags: got %b want 0000", {oWE, oBUSY, oDONE, oERR}); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_resync_ignore();
        test_checksum();
        test_back_to_back();
        test_framing_error();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
